// File: rtl/mecanismo_puertas.sv
// Door-actuator model: follows the door controller's commands, moves the door position and reports status/dwell timeout.
// Optional macro MECANISMO_OBSTACULO_EN lets the obstruction sensor reverse closing and restart the open dwell.
module mecanismo_puertas #(
    parameter int unsigned RECORRIDO = 8,
    parameter int unsigned ESPERA    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] salida_puertas,
    input  logic       sensor,
    output logic [1:0] puertas,
    output logic       timeout,
    output logic [7:0] posicion
);

    localparam int unsigned W = 8;

    localparam logic [1:0] CERRADA  = 2'b00;
    localparam logic [1:0] ABIERTA  = 2'b01;
    localparam logic [1:0] CERRANDO = 2'b10;
    localparam logic [1:0] ABRIENDO = 2'b11;

    localparam logic [W-1:0] POS_MAX   = W'(RECORRIDO);
    localparam logic [W-1:0] DWELL_MAX = W'(ESPERA);

    logic [1:0]   state_q, state_d;
    logic [W-1:0] pos_q, pos_d;
    logic [W-1:0] dwell_q, dwell_d;
    logic         timeout_q, timeout_d;

    logic abrir_c;
    logic cerrar_c;
    logic obst_c;

    assign abrir_c  = (salida_puertas == 2'b01);
    assign cerrar_c = (salida_puertas == 2'b10);

`ifdef MECANISMO_OBSTACULO_EN
    assign obst_c = sensor;
`else
    logic unused_sensor;
    assign unused_sensor = sensor;
    assign obst_c        = 1'b0;
`endif

    // Next state, position and dwell; position stays within 0..RECORRIDO
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dwell_d = '0;
        case (state_q)
            CERRADA: begin
                pos_d = '0;
                if (abrir_c) state_d = ABRIENDO;
            end
            ABRIENDO: begin
                if (cerrar_c) begin
                    state_d = CERRANDO;
                end else if (pos_q >= POS_MAX) begin
                    state_d = ABIERTA;
                end else begin
                    pos_d = pos_q + W'(1);
                    if (pos_d == POS_MAX) state_d = ABIERTA;
                end
            end
            ABIERTA: begin
                if (cerrar_c) begin
                    state_d = CERRANDO;
                end else if (abrir_c || obst_c) begin
                    dwell_d = '0;
                end else if (dwell_q < DWELL_MAX) begin
                    dwell_d = dwell_q + W'(1);
                end else begin
                    dwell_d = dwell_q;
                end
            end
            CERRANDO: begin
                // Reversal wins over the final step to closed
                if (abrir_c || obst_c) begin
                    state_d = ABRIENDO;
                end else if (pos_q == '0) begin
                    state_d = CERRADA;
                end else begin
                    pos_d = pos_q - W'(1);
                    if (pos_d == '0) state_d = CERRADA;
                end
            end
            default: begin
                state_d = CERRADA;
                pos_d   = '0;
            end
        endcase
        timeout_d = (state_d == ABIERTA) && (dwell_d == DWELL_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CERRADA;
            pos_q     <= '0;
            dwell_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            dwell_q   <= dwell_d;
            timeout_q <= timeout_d;
        end
    end

    assign puertas  = state_q;
    assign posicion = pos_q;
    assign timeout  = timeout_q;

endmodule
